msgpass_rqst_fetch: RTL and testbench

- Upstream feeder of memShare_control_wrapper; production replacement for the dummy message-pass address generator.
- Walks a contiguous window of the message-pass buffer and issues read addresses on buffer port A.
- Strips the per-lane flag bit from each returned word and presents the SHARE_GROUP_SIZE request addresses to the memShare controller as rqst_addr.
- Replays a word whenever the controller reports a detected read conflict (is_drc); drives the controller's busy input.

---
 rtl/msgpass_rqst_fetch.sv | 151 +++++++++++++++
 tb/tb_msgpass_rqst_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msgpass_rqst_fetch.sv
// Message-pass request fetcher: walks a window of the message-pass buffer, strips the
// per-lane flag bit and feeds request addresses to the memShare controller, replaying on conflicts.
module msgpass_rqst_fetch #(
   parameter int SHARE_GROUP_SIZE        = 5,
   parameter int RQST_ADDR_BITWIDTH      = 3,
   parameter int MSGPASS_BUFF_RQST_WIDTH = 4,
   parameter int MSGPASS_BUFF_ADDR_WIDTH = 4,
   parameter int MEMSHARE_DRC_NUM        = 1
) (
   input  logic                                                sys_clk,
   input  logic                                                rstn,
   input  logic                                                start_i,
   input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]                  base_addr_i,
   input  logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]                  len_i,
   input  logic                                                stop_i,
   output logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]                  raddr_o,
   input  logic [SHARE_GROUP_SIZE*MSGPASS_BUFF_RQST_WIDTH-1:0] rdata_i,
   input  logic [MEMSHARE_DRC_NUM-1:0]                         is_drc_i,
   output logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0]      rqst_addr_o,
   output logic                                                rqst_valid_o,
   output logic                                                busy_o,
   output logic                                                done_o
);

   localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] next_addr_q, next_addr_d;
   logic [AW-1:0] pres_addr_q, pres_addr_d;
   logic [AW-1:0] issued_q, issued_d;
   logic [AW-1:0] retired_q, retired_d;
   logic [AW-1:0] len_q, len_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;

   logic          stall;
   logic          retire;
   logic [SHARE_GROUP_SIZE-1:0] unused_flag_bits;

   assign stall   = valid_q & (|is_drc_i);
   assign retire  = valid_q & ~stall;
   assign raddr_o = stall ? pres_addr_q : next_addr_q;

   assign rqst_valid_o = valid_q;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;

   always_comb begin
      rqst_addr_o      = '0;
      unused_flag_bits = '0;
      for (int i = 0; i < SHARE_GROUP_SIZE; i++) begin
         unused_flag_bits[i] = rdata_i[i*MSGPASS_BUFF_RQST_WIDTH + MSGPASS_BUFF_RQST_WIDTH - 1];
         if (valid_q) begin
            rqst_addr_o[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] =
               rdata_i[i*MSGPASS_BUFF_RQST_WIDTH +: RQST_ADDR_BITWIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      pres_addr_d = pres_addr_q;
      issued_d    = issued_q;
      retired_d   = retired_q;
      len_d       = len_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d     = ISSUE;
                  next_addr_d = base_addr_i;
                  len_d       = len_i;
                  issued_d    = '0;
                  retired_d   = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         ISSUE: begin
            if (stop_i) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               // A stall freezes the issue side; the held word stays valid for replay.
               if (!stall) begin
                  next_addr_d = next_addr_q + ONE;
                  pres_addr_d = next_addr_q;
                  issued_d    = issued_q + ONE;
                  if (issued_q + ONE == len_q) begin
                     state_d = DRAIN;
                  end
               end
               valid_d = 1'b1;
               if (retire) begin
                  retired_d = retired_q + ONE;
               end
            end
         end

         DRAIN: begin
            if (stop_i) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               valid_d = stall;
               if (retire) begin
                  retired_d = retired_q + ONE;
                  if (retired_q + ONE == len_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rstn) begin
         state_q     <= IDLE;
         next_addr_q <= '0;
         pres_addr_q <= '0;
         issued_q    <= '0;
         retired_q   <= '0;
         len_q       <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         pres_addr_q <= pres_addr_d;
         issued_q    <= issued_d;
         retired_q   <= retired_d;
         len_q       <= len_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_msgpass_rqst_fetch.sv
// Table-driven bench for msgpass_rqst_fetch: cycle-by-cycle vectors with hand-computed
// expectations, backed by a 1-cycle-latency buffer model.
module tb_msgpass_rqst_fetch;

   localparam int SG = 5;
   localparam int RB = 3;
   localparam int BW = 4;
   localparam int AW = 4;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic              start_i = 1'b0;
   logic [AW-1:0]     base_addr_i = '0;
   logic [AW-1:0]     len_i = '0;
   logic              stop_i = 1'b0;
   logic [AW-1:0]     raddr_o;
   logic [SG*BW-1:0]  rdata_i = '0;
   logic [0:0]        is_drc_i = '0;
   logic [SG*RB-1:0]  rqst_addr_o;
   logic              rqst_valid_o;
   logic              busy_o;
   logic              done_o;

   logic [SG*BW-1:0]  mem [16];

   typedef struct {
      logic          rst;
      logic          start;
      logic          stop;
      logic          drc;
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      logic [AW-1:0] exp_raddr;
      logic          chk_raddr;
      logic          exp_valid;
      logic [AW-1:0] exp_word;
      logic          exp_busy;
      logic          exp_done;
   } vec_t;

   vec_t vecs[$];
   int   vec_count = 0;
   int   miscompares = 0;

   msgpass_rqst_fetch dut (
      .sys_clk      (clk),
      .rstn         (rstn),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .len_i        (len_i),
      .stop_i       (stop_i),
      .raddr_o      (raddr_o),
      .rdata_i      (rdata_i),
      .is_drc_i     (is_drc_i),
      .rqst_addr_o  (rqst_addr_o),
      .rqst_valid_o (rqst_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   // Buffer port A: registered read, data appears the cycle after the address.
   always @(posedge clk) begin
      rdata_i <= mem[raddr_o];
   end

   function automatic logic [SG*RB-1:0] exp_rqst(input logic valid, input logic [AW-1:0] word);
      logic [SG*RB-1:0] r;
      r = '0;
      if (valid) begin
         for (int i = 0; i < SG; i++) begin
            r[i*RB +: RB] = 3'((int'(word) + i) % 8);
         end
      end
      return r;
   endfunction

   task automatic add(input logic rst, input logic start, input logic stop, input logic drc,
                      input int base, input int len, input int er, input logic cr,
                      input logic ev, input int ew, input logic eb, input logic ed);
      vec_t v;
      v.rst = rst; v.start = start; v.stop = stop; v.drc = drc;
      v.base = 4'(base); v.len = 4'(len);
      v.exp_raddr = 4'(er); v.chk_raddr = cr;
      v.exp_valid = ev; v.exp_word = 4'(ew);
      v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic apply_stimulus(input vec_t v);
      @(negedge clk);
      rstn        = v.rst;
      start_i     = v.start;
      stop_i      = v.stop;
      is_drc_i    = v.drc;
      base_addr_i = v.base;
      len_i       = v.len;
      #2;
   endtask

   task automatic check_output(input int idx, input vec_t v);
      logic [SG*RB-1:0] er;
      er = exp_rqst(v.exp_valid, v.exp_word);
      vec_count++;
      if (v.chk_raddr && raddr_o !== v.exp_raddr) begin
         miscompares++;
         $display("[TB] FAIL vec%0d raddr_o got %0d want %0d", idx, raddr_o, v.exp_raddr);
      end
      if (rqst_valid_o !== v.exp_valid) begin
         miscompares++;
         $display("[TB] FAIL vec%0d rqst_valid_o got %0b want %0b", idx, rqst_valid_o, v.exp_valid);
      end
      if (rqst_addr_o !== er) begin
         miscompares++;
         $display("[TB] FAIL vec%0d rqst_addr_o got %h want %h", idx, rqst_addr_o, er);
      end
      if (busy_o !== v.exp_busy) begin
         miscompares++;
         $display("[TB] FAIL vec%0d busy_o got %0b want %0b", idx, busy_o, v.exp_busy);
      end
      if (done_o !== v.exp_done) begin
         miscompares++;
         $display("[TB] FAIL vec%0d done_o got %0b want %0b", idx, done_o, v.exp_done);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      apply_stimulus(v);
      check_output(idx, v);
   endtask

   initial begin
      vec_t hv;
      int   idx;

      // Every lane carries flag=1 above a 3-bit address of (word + lane) mod 8.
      for (int a = 0; a < 16; a++) begin
         for (int i = 0; i < SG; i++) begin
            mem[a][i*BW +: BW] = {1'b1, 3'((a + i) % 8)};
         end
      end

      repeat (2) @(posedge clk);

      // rst start stop drc base len | raddr chk valid word busy done
      add(1,0,0,0, 0,0,  0,1, 0,0,  0,0);
      // basic 3-word fetch from 0
      add(0,1,0,0, 0,3,  0,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  0,1, 0,0,  1,0);
      add(0,0,0,0, 0,0,  1,1, 1,0,  1,0);
      add(0,0,0,0, 0,0,  2,1, 1,1,  1,0);
      add(0,0,0,0, 0,0,  3,1, 1,2,  1,0);
      add(0,0,0,0, 0,0,  3,1, 0,0,  0,1);
      add(0,0,0,0, 0,0,  3,1, 0,0,  0,0);
      // conflict replay on word 5, drc ignored while nothing valid
      add(0,1,0,0, 4,3,  3,1, 0,0,  0,0);
      add(0,0,0,1, 0,0,  4,1, 0,0,  1,0);
      add(0,0,0,0, 0,0,  5,1, 1,4,  1,0);
      add(0,0,0,1, 0,0,  5,1, 1,5,  1,0);
      add(0,0,0,1, 0,0,  5,1, 1,5,  1,0);
      add(0,0,0,0, 0,0,  6,1, 1,5,  1,0);
      add(0,0,0,0, 0,0,  7,1, 1,6,  1,0);
      add(0,0,0,1, 0,0,  7,1, 0,0,  0,1);
      // wrap 14,15,0,1 with a replay during drain
      add(0,1,0,0, 14,4, 7,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  14,1,0,0,  1,0);
      add(0,0,0,0, 0,0,  15,1,1,14, 1,0);
      add(0,0,0,0, 0,0,  0,1, 1,15, 1,0);
      add(0,0,0,0, 0,0,  1,1, 1,0,  1,0);
      add(0,0,0,1, 0,0,  1,1, 1,1,  1,0);
      add(0,0,0,0, 0,0,  2,1, 1,1,  1,0);
      add(0,0,0,0, 0,0,  2,1, 0,0,  0,1);
      // abort on second valid cycle, restart immediately with len 1
      add(0,1,0,0, 8,5,  2,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  8,1, 0,0,  1,0);
      add(0,0,0,0, 0,0,  9,1, 1,8,  1,0);
      add(0,0,1,0, 0,0,  10,1,1,9,  1,0);
      add(0,1,0,0, 3,1,  0,0, 0,0,  0,1);
      add(0,0,0,0, 0,0,  3,1, 0,0,  1,0);
      add(0,0,0,0, 0,0,  4,1, 1,3,  1,0);
      add(0,0,0,0, 0,0,  4,1, 0,0,  0,1);
      // len 0 is a no-op with a done pulse
      add(0,1,0,0, 9,0,  4,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  4,1, 0,0,  0,1);
      add(0,0,0,0, 0,0,  4,1, 0,0,  0,0);
      // start wins over stop in IDLE; starts during a sequence are ignored
      add(0,1,1,0, 12,2, 4,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  12,1,0,0,  1,0);
      add(0,1,0,0, 0,5,  13,1,1,12, 1,0);
      add(0,1,0,0, 0,5,  14,1,1,13, 1,0);
      add(0,0,0,0, 0,0,  14,1,0,0,  0,1);
      add(0,0,1,0, 0,0,  14,1,0,0,  0,0);
      add(0,0,0,0, 0,0,  14,1,0,0,  0,0);
      // reset mid-sequence discards work without a done pulse
      add(0,1,0,0, 2,6,  14,1,0,0,  0,0);
      add(0,0,0,0, 0,0,  2,1, 0,0,  1,0);
      add(0,0,0,0, 0,0,  3,1, 1,2,  1,0);
      add(1,0,0,0, 0,0,  4,1, 1,3,  1,0);
      add(1,0,0,0, 0,0,  0,1, 0,0,  0,0);
      add(1,0,0,0, 0,0,  0,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  0,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  0,1, 0,0,  0,0);

      for (int k = 0; k < vecs.size(); k++) begin
         run_vec(k, vecs[k]);
      end
      idx = vecs.size();

      // Long conflict run on the last word: replay has no limit.
      vecs.delete();
      add(0,1,0,0, 5,2,  0,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  5,1, 0,0,  1,0);
      add(0,0,0,0, 0,0,  6,1, 1,5,  1,0);
      for (int k = 0; k < vecs.size(); k++) begin
         run_vec(idx, vecs[k]);
         idx++;
      end
      for (int s = 0; s < 8; s++) begin
         hv = '{rst:1'b0, start:1'b0, stop:1'b0, drc:1'b1, base:4'd0, len:4'd0,
                exp_raddr:4'd6, chk_raddr:1'b1, exp_valid:1'b1, exp_word:4'd6,
                exp_busy:1'b1, exp_done:1'b0};
         run_vec(idx, hv);
         idx++;
      end
      hv = '{rst:1'b0, start:1'b0, stop:1'b0, drc:1'b0, base:4'd0, len:4'd0,
             exp_raddr:4'd7, chk_raddr:1'b1, exp_valid:1'b1, exp_word:4'd6,
             exp_busy:1'b1, exp_done:1'b0};
      run_vec(idx, hv);
      idx++;
      hv = '{rst:1'b0, start:1'b0, stop:1'b0, drc:1'b0, base:4'd0, len:4'd0,
             exp_raddr:4'd7, chk_raddr:1'b1, exp_valid:1'b0, exp_word:4'd0,
             exp_busy:1'b0, exp_done:1'b1};
      run_vec(idx, hv);
      idx++;

      // Stop during DRAIN aborts the remaining word.
      vecs.delete();
      add(0,1,0,0, 10,2, 7,1, 0,0,  0,0);
      add(0,0,0,0, 0,0,  10,1,0,0,  1,0);
      add(0,0,0,0, 0,0,  11,1,1,10, 1,0);
      add(0,0,1,0, 0,0,  12,1,1,11, 1,0);
      add(0,0,0,0, 0,0,  0,0, 0,0,  0,1);
      add(0,0,0,0, 0,0,  0,0, 0,0,  0,0);
      for (int k = 0; k < vecs.size(); k++) begin
         run_vec(idx, vecs[k]);
         idx++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
